memq: RTL and testbench

MEMQ -- requirements
Module: memq

---
 rtl/memq.sv | 114 +++++++++++
 tb/tb_memq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/memq.sv
// Request queue in front of a memory controller: buffers CPU read/write requests
// and issues them one at a time, returning read data after a fixed latency.
module memq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                    memq_clk,
    input  logic                    memq_reset,
    input  logic                    cpu_req_valid,
    output logic                    cpu_req_ready,
    input  logic                    cpu_req_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_req_wdata,
    output logic                    cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   cpu_rsp_data,
    input  logic                    memc_busy,
    output logic                    memc_read_enable,
    output logic                    memc_write_enable,
    output logic [ADDR_WIDTH-1:0]   memc_addr,
    output logic [DATA_WIDTH-1:0]   memc_write_data,
    input  logic [DATA_WIDTH-1:0]   memc_read_data,
    output logic [$clog2(DEPTH):0]  memq_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        ISSUE = 3'b010,
        WAIT  = 3'b100
    } state_t;

    req_t          queue [DEPTH];
    req_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    state_t        state;
    logic [2:0]    wait_cnt;
    logic          cur_rd;

    // Ready is derived from the registered level, so a pop in the same cycle never opens a full queue.
    assign cpu_req_ready = (memq_level < LW'(DEPTH)) && memq_reset;
    assign push          = cpu_req_valid && cpu_req_ready;
    assign pop           = (state == ISSUE);
    assign head          = queue[rd_ptr];

    always_ff @(posedge memq_clk) begin
        if (push) queue[wr_ptr] <= {cpu_req_we, cpu_req_addr, cpu_req_wdata};
    end

    always_ff @(posedge memq_clk or negedge memq_reset) begin
        if (!memq_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            memq_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            memq_level <= memq_level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge memq_clk or negedge memq_reset) begin
        if (!memq_reset) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            cur_rd            <= 1'b0;
            memc_read_enable  <= 1'b0;
            memc_write_enable <= 1'b0;
            memc_addr         <= '0;
            memc_write_data   <= '0;
            cpu_rsp_valid     <= 1'b0;
            cpu_rsp_data      <= '0;
        end else begin
            memc_read_enable  <= 1'b0;
            memc_write_enable <= 1'b0;
            cpu_rsp_valid     <= 1'b0;
            case (state)
                IDLE: begin
                    if (memq_level != '0 && !memc_busy) begin
                        state             <= ISSUE;
                        memc_read_enable  <= ~head.we;
                        memc_write_enable <= head.we;
                        memc_addr         <= head.addr;
                        memc_write_data   <= head.wdata;
                        cur_rd            <= ~head.we;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= cur_rd ? 3'(RD_LATENCY) : 3'd1;
                end
                WAIT: begin
                    // Capture happens exactly once at expiry; the count then parks at 0 while busy holds us here.
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1 && cur_rd) begin
                        cpu_rsp_data  <= memc_read_data;
                        cpu_rsp_valid <= 1'b1;
                    end
                    if (wait_cnt <= 3'd1 && !memc_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memq.sv
// Directed and randomized checks of memq against a queue/scoreboard model that
// also plays the memory controller (latency-timed read data, write storage).
module tb_memq;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic          memq_clk = 1'b0;
    logic          memq_reset, cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [AW-1:0] cpu_req_addr, memc_addr;
    logic [DW-1:0] cpu_req_wdata, cpu_rsp_data, memc_write_data, memc_read_data;
    logic          cpu_rsp_valid, memc_busy, memc_read_enable, memc_write_enable;
    logic [2:0]    memq_level;

    memq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
        .memq_clk(memq_clk), .memq_reset(memq_reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
        .memc_busy(memc_busy), .memc_read_enable(memc_read_enable),
        .memc_write_enable(memc_write_enable), .memc_addr(memc_addr),
        .memc_write_data(memc_write_data), .memc_read_data(memc_read_data),
        .memq_level(memq_level)
    );

    always #5 memq_clk = ~memq_clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    req_t          q[$];
    logic [DW-1:0] mem_m [logic [AW-1:0]];
    int            cyc = 0, lvl_m = 0, n_chk = 0, n_pass = 0, n_fail = 0;
    int            n_cmd = 0, n_rsp = 0, n_acc = 0;
    int            rsp_due = -1, smp_cyc = -1, last_cmd_cyc = -100, last_load = 0, last_rsp_cyc = -1;
    logic [DW-1:0] smp_val = '0, last_rsp_data = '0;
    logic          last_cmd_we = 1'b0, prev_busy = 1'b0;

    bit            fw [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [AW-1:0] fa [5] = '{16'h0010, 16'h0010, 16'h0020, 16'h0020, 16'h0030};
    logic [DW-1:0] fd [5] = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h33};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (!mem_m.exists(a)) mem_m[a] = DW'($urandom);
        return mem_m[a];
    endfunction

    // One clock cycle: observe outputs mid-cycle, update the model, return just after the edge.
    task automatic tick();
        bit   cmd, acc;
        req_t e;
        @(negedge memq_clk);
        memc_read_data = DW'($urandom);
        if (!memq_reset) begin
            chk("rst_outs", 64'({cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, memc_read_enable,
                memc_write_enable, memc_addr, memc_write_data, memq_level}), 64'd0);
            q.delete();
            lvl_m = 0; rsp_due = -1; smp_cyc = -1; last_cmd_cyc = -100; last_rsp_data = '0;
        end else begin
            chk("level", 64'(memq_level), 64'(lvl_m));
            chk("ready", 64'(cpu_req_ready), 64'(lvl_m < DEPTH));
            chk("rd_wr_excl", 64'(memc_read_enable && memc_write_enable), 64'd0);
            cmd = memc_read_enable || memc_write_enable;
            if (cmd) begin
                n_cmd++;
                chk("cmd_expected", 64'(q.size() != 0), 64'd1);
                chk("cmd_after_busy", 64'(prev_busy), 64'd0);
                chk("cmd_gap", 64'((cyc - last_cmd_cyc) >= (2 + last_load)), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("cmd_we", 64'(memc_write_enable), 64'(e.we));
                    chk("cmd_addr", 64'(memc_addr), 64'(e.addr));
                    if (e.we) begin
                        chk("cmd_wdata", 64'(memc_write_data), 64'(e.wdata));
                        mem_m[e.addr] = e.wdata;
                    end else begin
                        smp_val = mem_rd(e.addr);
                        smp_cyc = cyc + LAT;
                        rsp_due = cyc + LAT + 1;
                    end
                    last_load = e.we ? 1 : LAT;
                end
                last_cmd_cyc = cyc;
                last_cmd_we  = memc_write_enable;
            end
            chk("rsp_valid", 64'(cpu_rsp_valid), 64'(cyc == rsp_due));
            if (cpu_rsp_valid) begin
                if (cyc == rsp_due) chk("rsp_data", 64'(cpu_rsp_data), 64'(smp_val));
                n_rsp++;
                last_rsp_cyc  = cyc;
                last_rsp_data = cpu_rsp_data;
            end else begin
                chk("rsp_hold", 64'(cpu_rsp_data), 64'(last_rsp_data));
            end
            if (cyc == smp_cyc) memc_read_data = smp_val;
            acc = cpu_req_valid && (lvl_m < DEPTH);
            if (acc) begin
                q.push_back('{we: cpu_req_we, addr: cpu_req_addr, wdata: cpu_req_wdata});
                n_acc++;
            end
            lvl_m = lvl_m + int'(acc) - int'(cmd);
        end
        prev_busy = memc_busy;
        @(posedge memq_clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = d;
        tick();
        cpu_req_valid = 1'b0;
    endtask

    initial begin
        int c0, b_rsp, b_cmd, b_acc;
        memq_reset = 1'b0; cpu_req_valid = 1'b1; cpu_req_we = 1'b1;
        cpu_req_addr = 16'h1234; cpu_req_wdata = 8'h77; memc_busy = 1'b0; memc_read_data = '0;

        // Reset held with a request pending: nothing may be queued.
        repeat (3) tick();
        cpu_req_valid = 1'b0;
        memq_reset = 1'b1;
        #1;
        chk("rel_ready", 64'(cpu_req_ready), 64'd1);
        chk("rel_level", 64'(memq_level), 64'd0);
        tick();

        // Single write from empty.
        c0 = cyc; b_rsp = n_rsp;
        drive(1'b1, 16'h0200, 8'hA5);
        repeat (6) tick();
        chk("wr_cycle", 64'(last_cmd_cyc - c0), 64'd2);
        chk("wr_is_write", 64'(last_cmd_we), 64'd1);
        chk("wr_no_rsp", 64'(n_rsp - b_rsp), 64'd0);
        chk("wr_addr_hold", 64'(memc_addr), 64'h0200);
        chk("wr_data_hold", 64'(memc_write_data), 64'hA5);

        // Read it back: response at cycle 3+LAT.
        c0 = cyc; b_rsp = n_rsp;
        drive(1'b0, 16'h0200, 8'h00);
        repeat (8) tick();
        chk("rd_rsp_cycle", 64'(last_rsp_cyc - c0), 64'd5);
        chk("rd_rsp_data", 64'(last_rsp_data), 64'hA5);
        chk("rd_rsp_count", 64'(n_rsp - b_rsp), 64'd1);

        // Busy controller: queue fills to DEPTH, then drains in order.
        memc_busy = 1'b1; b_acc = n_acc; b_cmd = n_cmd;
        cpu_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_req_we = fw[i]; cpu_req_addr = fa[i]; cpu_req_wdata = fd[i];
            tick();
        end
        cpu_req_valid = 1'b0;
        tick();
        chk("full_level", 64'(memq_level), 64'd4);
        chk("full_ready", 64'(cpu_req_ready), 64'd0);
        chk("full_accepted", 64'(n_acc - b_acc), 64'd4);
        chk("full_no_cmd", 64'(n_cmd - b_cmd), 64'd0);
        memc_busy = 1'b0;
        repeat (20) tick();
        chk("drain_cmds", 64'(n_cmd - b_cmd), 64'd4);
        chk("drain_level", 64'(memq_level), 64'd0);

        // Busy raised during the WAIT of a read, with a write queued behind it.
        c0 = cyc; b_rsp = n_rsp;
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 16'h0300; cpu_req_wdata = 8'h00;
        tick();
        cpu_req_we = 1'b1; cpu_req_addr = 16'h0310; cpu_req_wdata = 8'h5A;
        tick();
        cpu_req_valid = 1'b0;
        tick();
        memc_busy = 1'b1;
        repeat (6) tick();
        memc_busy = 1'b0;
        repeat (6) tick();
        chk("busyw_rsp_count", 64'(n_rsp - b_rsp), 64'd1);
        chk("busyw_rsp_cycle", 64'(last_rsp_cyc - c0), 64'd5);
        chk("busyw_next_cycle", 64'(last_cmd_cyc - c0), 64'd11);
        chk("busyw_next_we", 64'(last_cmd_we), 64'd1);

        // Reset during the WAIT of a read with two requests queued.
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 16'h0400;
        tick();
        cpu_req_we = 1'b1; cpu_req_addr = 16'h0410; cpu_req_wdata = 8'h41;
        tick();
        cpu_req_addr = 16'h0420; cpu_req_wdata = 8'h42;
        tick();
        cpu_req_valid = 1'b0;
        chk("rstw_level_before", 64'(memq_level), 64'd2);
        b_rsp = n_rsp; b_cmd = n_cmd;
        memq_reset = 1'b0;
        repeat (2) tick();
        memq_reset = 1'b1;
        repeat (10) tick();
        chk("rstw_no_rsp", 64'(n_rsp - b_rsp), 64'd0);
        chk("rstw_no_cmd", 64'(n_cmd - b_cmd), 64'd0);
        chk("rstw_level", 64'(memq_level), 64'd0);

        // Randomized traffic over a small address set, with random busy.
        for (int i = 0; i < 300; i++) begin
            cpu_req_valid = 1'($urandom_range(0, 1));
            cpu_req_we    = 1'($urandom_range(0, 1));
            cpu_req_addr  = 16'($urandom_range(0, 7));
            cpu_req_wdata = DW'($urandom);
            memc_busy     = ($urandom_range(0, 4) == 0);
            tick();
        end
        cpu_req_valid = 1'b0; memc_busy = 1'b0;
        for (int i = 0; i < 100 && (q.size() != 0 || rsp_due >= cyc); i++) tick();
        repeat (2) tick();
        chk("final_queue_empty", 64'(q.size()), 64'd0);
        chk("final_no_pending", 64'(rsp_due >= cyc), 64'd0);
        chk("final_level", 64'(memq_level), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
